// File: rtl/cdc_fifo_pkg.sv
// Shared definitions for the CDC FIFO write side: arbiter state encoding
// and default FIFO geometry.
package cdc_fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int DATA_W_DEFAULT = 8;
    localparam int FIFO_DEPTH     = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid requester strictly after the last grant,
// wrapping modulo N_REQ.
module rr_pick
    import cdc_fifo_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        idx_o   = '0;
        found_o = 1'b0;
        // Scan last+1 .. last+N_REQ; the grant holder itself is checked last.
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found_o && valid_i[(int'(last_i) + k) % N_REQ]) begin
                idx_o   = IDX_W'((int'(last_i) + k) % N_REQ);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdc_fifo_write_arbiter.sv
// Write-side scheduler for the CDC FIFO: round-robin, packet-locked sharing of
// the FIFO write port, with writes paced to tolerate the lagging full flag.
module cdc_fifo_write_arbiter
    import cdc_fifo_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int FULL_LAG = 2,
    parameter int MAX_PKT  = 16,
    parameter int ID_W     = $clog2(N_REQ),
    parameter int CNT_W    = $clog2(MAX_PKT + 1)
) (
    input  logic                    write_clk,
    input  logic                    write_rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_full,
    output logic [DATA_W-1:0]       fifo_write_data,
    output logic                    fifo_write_enable,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic                    pkt_overrun
);

    arb_state_e        state_q;
    logic [ID_W-1:0]   grant_q;
    logic              wr_en_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              overrun_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [CNT_W-1:0]  beat_cnt_d;
    logic [FULL_LAG:0] hist_q;
    logic [FULL_LAG:0] hist_d;

    logic [ID_W-1:0]   pick_idx;
    logic              pick_found;
    logic              can_write;
    logic              accept;
    logic [DATA_W-1:0] owner_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (ID_W)
    ) u_rr_pick (
        .valid_i (req_valid),
        .last_i  (grant_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // No accept until every earlier write has had time to show up in fifo_full.
    assign can_write  = !fifo_full && (hist_q == '0);
    assign accept     = (state_q == LOCK) && req_valid[grant_q] && can_write;
    assign owner_data = req_data[grant_q*DATA_W +: DATA_W];
    assign beat_cnt_d = beat_cnt_q + 1'b1;
    assign hist_d     = {hist_q[FULL_LAG-1:0], accept};

    always_comb begin
        req_ready = '0;
        if (state_q == LOCK) begin
            req_ready[grant_q] = can_write;
        end
    end

    always_ff @(posedge write_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (write_rst) begin
            state_q    <= IDLE;
            grant_q    <= ID_W'(N_REQ - 1);
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            overrun_q  <= 1'b0;
            beat_cnt_q <= '0;
            hist_q     <= '0;
        end else begin
            hist_q  <= hist_d;
            wr_en_q <= accept;
            if (accept) begin
                wr_data_q <= owner_data;
            end
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q    <= pick_idx;
                        beat_cnt_q <= '0;
                        state_q    <= LOCK;
                    end
                end
                LOCK: begin
                    if (accept) begin
                        beat_cnt_q <= beat_cnt_d;
                        if (req_last[grant_q]) begin
                            state_q <= IDLE;
                        end else if (beat_cnt_d == CNT_W'(MAX_PKT)) begin
                            // Forced release; the rest of the packet competes as a new grant.
                            state_q   <= IDLE;
                            overrun_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_write_enable = wr_en_q;
    assign fifo_write_data   = wr_data_q;
    assign grant_id          = grant_q;
    assign busy              = (state_q == LOCK);
    assign pkt_overrun       = overrun_q;

endmodule
